// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: dual-channel PWM motor driver for the line follower.
// Uses the divided clock on TICK_IN as a PWM time base (synchronised and
// edge-detected, never used as a clock). Each channel soft-ramps its duty
// and runs a brake / dead-time sequence on direction reversal so the
// H-bridge is never switched while driven.
//
// Ports (top):
//   CLK_IN              system clock, rising edge
//   RST                 asynchronous active-high reset
//   TICK_IN             divided clock, one PWM tick per rising edge
//   ENABLE_IN           motor enable, low forces both channels to IDLE
//   DUTY_L_IN/DUTY_R_IN target duty per channel
//   DIR_L_IN/DIR_R_IN   requested direction per channel (1 = forward)
//   PWM_L_OUT/PWM_R_OUT registered PWM drive
//   DIR_L_OUT/DIR_R_OUT registered applied direction
//   BUSY_OUT            registered, high while a channel is braking or in dead time

// One motor channel: ramp/brake/dead-time FSM plus registered PWM compare.
// Ports:
//   i_clk, i_rst   clock and async active-high reset
//   i_tick         one-cycle PWM tick pulse
//   i_bnd          tick on the last count of the period
//   i_enable       global enable
//   i_duty, i_dir  target duty and requested direction
//   i_cnt_nxt      period counter value after this cycle
//   o_pwm, o_dir   registered drive and applied direction
//   o_busy_nxt_c   next-cycle braking/dead flag (combinational)
module motor_pwm_chan #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned RAMP_STEP  = 4,
  parameter int unsigned DEAD_TICKS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_bnd,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_dir,
  input  logic [PWM_BITS-1:0] i_cnt_nxt,
  output logic                o_pwm,
  output logic                o_dir,
  output logic                o_busy_nxt_c
);

  localparam int unsigned DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [PWM_BITS-1:0] STEP_W    = PWM_BITS'(RAMP_STEP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_RDOWN = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;

  logic [1:0]          r_state, w_state_nxt;
  logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
  logic                r_dir, w_dir_nxt;
  logic [DW-1:0]       r_dead, w_dead_nxt;
  logic                r_pwm, w_pwm_nxt;

  // Move cur toward tgt by at most one ramp step, never overshooting.
  function automatic logic [PWM_BITS-1:0] f_ramp(input logic [PWM_BITS-1:0] cur,
                                                 input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] diff;
    if (cur < tgt) begin
      diff   = tgt - cur;
      f_ramp = (diff > STEP_W) ? cur + STEP_W : tgt;
    end else begin
      diff   = cur - tgt;
      f_ramp = (diff > STEP_W) ? cur - STEP_W : tgt;
    end
  endfunction

  // Next-state logic; enable low overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir;
    w_dead_nxt  = r_dead;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_duty_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_duty_nxt  = '0;
          w_state_nxt = ST_RUN;
          w_dir_nxt   = i_dir;
        end
        ST_RUN: begin
          // Ramp uses the pre-transition target even if direction flips now.
          if (i_bnd) w_duty_nxt = f_ramp(r_duty, i_duty);
          if (i_dir != r_dir) w_state_nxt = ST_RDOWN;
        end
        ST_RDOWN: begin
          if (i_bnd) w_duty_nxt = f_ramp(r_duty, '0);
          if (i_dir == r_dir) begin
            w_state_nxt = ST_RUN;
          end else if (i_bnd && (w_duty_nxt == '0)) begin
            w_state_nxt = ST_DEAD;
            w_dead_nxt  = '0;
          end
        end
        ST_DEAD: begin
          w_duty_nxt = '0;
          if (i_tick) begin
            if (r_dead == DEAD_LAST) begin
              w_state_nxt = ST_RUN;
              w_dir_nxt   = i_dir;
              w_dead_nxt  = '0;
            end else begin
              w_dead_nxt = r_dead + DW'(1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // PWM register is fed from next-state values so it always matches
  // the state/duty/counter registers it sits beside.
  assign w_pwm_nxt    = (w_state_nxt == ST_RUN) && (w_duty_nxt > i_cnt_nxt);
  assign o_busy_nxt_c = (w_state_nxt == ST_RDOWN) || (w_state_nxt == ST_DEAD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_dir   <= 1'b0;
      r_dead  <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_dir   <= w_dir_nxt;
      r_dead  <= w_dead_nxt;
      r_pwm   <= w_pwm_nxt;
    end
  end

  assign o_pwm = r_pwm;
  assign o_dir = r_dir;

endmodule

module motor_pwm_driver #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned RAMP_STEP  = 4,
  parameter int unsigned DEAD_TICKS = 16
) (
  input  logic                CLK_IN,
  input  logic                RST,
  input  logic                TICK_IN,
  input  logic                ENABLE_IN,
  input  logic [PWM_BITS-1:0] DUTY_L_IN,
  input  logic                DIR_L_IN,
  input  logic [PWM_BITS-1:0] DUTY_R_IN,
  input  logic                DIR_R_IN,
  output logic                PWM_L_OUT,
  output logic                DIR_L_OUT,
  output logic                PWM_R_OUT,
  output logic                DIR_R_OUT,
  output logic                BUSY_OUT
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic                r_sync1, r_sync2, r_sync3;
  logic                w_tick, w_bnd;
  logic [PWM_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                w_busy_l, w_busy_r;
  logic                r_busy;

  // r_sync1/r_sync2 resynchronise TICK_IN; r_sync3 is the edge-detect history.
  assign w_tick    = r_sync2 & ~r_sync3;
  assign w_bnd     = w_tick && (r_cnt == CNT_MAX);
  assign w_cnt_nxt = w_tick ? r_cnt + PWM_BITS'(1) : r_cnt;

  // Tick synchroniser and shared period counter.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= TICK_IN;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_cnt   <= w_cnt_nxt;
    end
  end

  motor_pwm_chan #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP),
    .DEAD_TICKS(DEAD_TICKS)
  ) u_chan_l (
    .i_clk       (CLK_IN),
    .i_rst       (RST),
    .i_tick      (w_tick),
    .i_bnd       (w_bnd),
    .i_enable    (ENABLE_IN),
    .i_duty      (DUTY_L_IN),
    .i_dir       (DIR_L_IN),
    .i_cnt_nxt   (w_cnt_nxt),
    .o_pwm       (PWM_L_OUT),
    .o_dir       (DIR_L_OUT),
    .o_busy_nxt_c(w_busy_l)
  );

  motor_pwm_chan #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP),
    .DEAD_TICKS(DEAD_TICKS)
  ) u_chan_r (
    .i_clk       (CLK_IN),
    .i_rst       (RST),
    .i_tick      (w_tick),
    .i_bnd       (w_bnd),
    .i_enable    (ENABLE_IN),
    .i_duty      (DUTY_R_IN),
    .i_dir       (DIR_R_IN),
    .i_cnt_nxt   (w_cnt_nxt),
    .o_pwm       (PWM_R_OUT),
    .o_dir       (DIR_R_OUT),
    .o_busy_nxt_c(w_busy_r)
  );

  // Busy flag registered alongside the channel state registers.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) r_busy <= 1'b0;
    else     r_busy <= w_busy_l | w_busy_r;
  end

  assign BUSY_OUT = r_busy;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Testbench for motor_pwm_driver: directed sequence with randomized tick
// timing and mid-period duty noise, checked every cycle against a
// behavioural model plus fixed expectations for ramp, reversal and extremes.
module tb_motor_pwm_driver;

  localparam int RAMP = 4;
  localparam int DEAD = 16;
  localparam int PER  = 256;

  localparam int MS_IDLE = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_RDN  = 2;
  localparam int MS_DEAD = 3;

  logic       CLK_IN = 1'b0;
  logic       RST, TICK_IN, ENABLE_IN, DIR_L_IN, DIR_R_IN;
  logic [7:0] DUTY_L_IN, DUTY_R_IN;
  logic       PWM_L_OUT, DIR_L_OUT, PWM_R_OUT, DIR_R_OUT, BUSY_OUT;

  always #5 CLK_IN = ~CLK_IN;

  motor_pwm_driver #(.PWM_BITS(8), .RAMP_STEP(RAMP), .DEAD_TICKS(DEAD)) dut (
    .CLK_IN   (CLK_IN),
    .RST      (RST),
    .TICK_IN  (TICK_IN),
    .ENABLE_IN(ENABLE_IN),
    .DUTY_L_IN(DUTY_L_IN),
    .DIR_L_IN (DIR_L_IN),
    .DUTY_R_IN(DUTY_R_IN),
    .DIR_R_IN (DIR_R_IN),
    .PWM_L_OUT(PWM_L_OUT),
    .DIR_L_OUT(DIR_L_OUT),
    .PWM_R_OUT(PWM_R_OUT),
    .DIR_R_OUT(DIR_R_OUT),
    .BUSY_OUT (BUSY_OUT)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state
  bit m_hist[3];
  int m_cnt;
  bit m_tick;
  int m_st[2], m_duty[2], m_dir[2], m_dead[2];

  // Duty-cycle measurement over whole periods
  bit meas;
  int meas_ticks, hi_l, hi_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20) $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int approach(input int cur, input int tgt);
    if (cur < tgt) return cur + (((tgt - cur) < RAMP) ? (tgt - cur) : RAMP);
    if (cur > tgt) return cur - (((cur - tgt) < RAMP) ? (cur - tgt) : RAMP);
    return cur;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_hist[i] = 1'b0;
    m_cnt  = 0;
    m_tick = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_st[c] = MS_IDLE; m_duty[c] = 0; m_dir[c] = 0; m_dead[c] = 0;
    end
  endtask

  // One rising edge of the model, using inputs as they stand at the edge.
  task automatic model_edge();
    bit tk, bnd;
    int din, dirin;
    if (RST) begin
      model_reset();
      return;
    end
    // A rise of TICK_IN counts on the third edge after it is first sampled.
    tk = m_hist[1] && !m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = TICK_IN;
    bnd = tk && (m_cnt == PER - 1);
    for (int c = 0; c < 2; c++) begin
      din   = (c == 0) ? int'(DUTY_L_IN) : int'(DUTY_R_IN);
      dirin = (c == 0) ? int'(DIR_L_IN) : int'(DIR_R_IN);
      if (!ENABLE_IN) begin
        m_st[c] = MS_IDLE;
        m_duty[c] = 0;
      end else if (m_st[c] == MS_IDLE) begin
        m_st[c] = MS_RUN;
        m_dir[c] = dirin;
        m_duty[c] = 0;
      end else if (m_st[c] == MS_RUN) begin
        if (bnd) m_duty[c] = approach(m_duty[c], din);
        if (dirin != m_dir[c]) m_st[c] = MS_RDN;
      end else if (m_st[c] == MS_RDN) begin
        if (bnd) m_duty[c] = approach(m_duty[c], 0);
        if (dirin == m_dir[c]) m_st[c] = MS_RUN;
        else if (bnd && m_duty[c] == 0) begin
          m_st[c] = MS_DEAD;
          m_dead[c] = 0;
        end
      end else begin
        if (tk) begin
          m_dead[c]++;
          if (m_dead[c] == DEAD) begin
            m_st[c] = MS_RUN;
            m_dir[c] = dirin;
            m_duty[c] = 0;
          end
        end
      end
    end
    if (tk) m_cnt = (m_cnt + 1) % PER;
    m_tick = tk;
  endtask

  function automatic bit exp_pwm(input int c);
    return (m_st[c] == MS_RUN) && (m_duty[c] > m_cnt);
  endfunction

  function automatic bit exp_busy();
    return (m_st[0] == MS_RDN) || (m_st[0] == MS_DEAD) ||
           (m_st[1] == MS_RDN) || (m_st[1] == MS_DEAD);
  endfunction

  task automatic check_model();
    chk("pwm_l", PWM_L_OUT, exp_pwm(0));
    chk("pwm_r", PWM_R_OUT, exp_pwm(1));
    chk("dir_l", DIR_L_OUT, m_dir[0]);
    chk("dir_r", DIR_R_OUT, m_dir[1]);
    chk("busy", BUSY_OUT, exp_busy());
  endtask

  task automatic cyc();
    @(posedge CLK_IN);
    model_edge();
    #1;
    check_model();
    if (meas && m_tick) begin
      meas_ticks++;
      hi_l += int'(PWM_L_OUT);
      hi_r += int'(PWM_R_OUT);
    end
  endtask

  // One TICK_IN pulse with randomized low time.
  task automatic tick_pulse();
    TICK_IN = 1'b1;
    cyc();
    TICK_IN = 1'b0;
    cyc();
    if ($urandom_range(3) == 0) cyc();
  endtask

  // n pulses, then let the synchroniser drain so all n ticks have landed.
  task automatic run_ticks(input int n);
    repeat (n) tick_pulse();
    cyc();
    cyc();
  endtask

  task automatic to_boundary();
    run_ticks(PER - m_cnt);
  endtask

  task automatic measure_period();
    meas = 1'b1; meas_ticks = 0; hi_l = 0; hi_r = 0;
    run_ticks(PER);
    meas = 1'b0;
  endtask

  // One period with random duty noise mid-period, restored before the boundary.
  task automatic period(input int tl, input int tr, input int el, input int er, input int k);
    DUTY_L_IN = 8'($urandom_range(255));
    DUTY_R_IN = 8'($urandom_range(255));
    run_ticks(64 + $urandom_range(64));
    DUTY_L_IN = 8'(tl);
    DUTY_R_IN = 8'(tr);
    to_boundary();
    chk($sformatf("duty_l_p%0d", k), dut.u_chan_l.r_duty, el);
    chk($sformatf("duty_r_p%0d", k), dut.u_chan_r.r_duty, er);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; TICK_IN = 1'b0; ENABLE_IN = 1'b0;
    DUTY_L_IN = 8'd0; DUTY_R_IN = 8'd0; DIR_L_IN = 1'b0; DIR_R_IN = 1'b0;
    meas = 1'b0; meas_ticks = 0; hi_l = 0; hi_r = 0;
    model_reset();
    repeat (3) cyc();
    chk("rst_cnt", dut.r_cnt, 0);
    chk("rst_busy", BUSY_OUT, 0);
    RST = 1'b0;
    cyc();

    // Tick integrity: one count per rising edge, 3-cycle latency
    TICK_IN = 1'b1;
    cyc(); cyc();
    chk("tick_lat2", dut.r_cnt, 0);
    cyc();
    chk("tick_lat3", dut.r_cnt, 1);
    repeat (47) cyc();
    chk("tick_held", dut.r_cnt, 1);
    TICK_IN = 1'b0;
    cyc(); cyc();

    // Ramp up: left to 100, right toward 255
    ENABLE_IN = 1'b1; DIR_L_IN = 1'b1; DIR_R_IN = 1'b1;
    DUTY_L_IN = 8'd100; DUTY_R_IN = 8'd255;
    cyc();
    chk("en_dir_l", DIR_L_OUT, 1);
    chk("en_dir_r", DIR_R_OUT, 1);
    for (int k = 1; k <= 25; k++) period(100, 255, 4 * k, 4 * k, k);

    // Full-period duty at 100; 102 request must wait for the boundary
    DUTY_L_IN = 8'd102; DUTY_R_IN = 8'd255;
    meas = 1'b1; meas_ticks = 0; hi_l = 0; hi_r = 0;
    run_ticks(128);
    chk("duty_l_hold", dut.u_chan_l.r_duty, 100);
    run_ticks(128);
    meas = 1'b0;
    chk("meas_ticks_100", meas_ticks, 256);
    chk("hi_l_100", hi_l, 100);
    chk("duty_l_102", dut.u_chan_l.r_duty, 102);
    chk("duty_r_p26", dut.u_chan_r.r_duty, 104);

    // Ramp down to 20 without undershoot
    for (int k = 27; k <= 47; k++)
      period(20, 255, (102 - 4 * (k - 26) > 20) ? 102 - 4 * (k - 26) : 20, min_i(4 * k, 255), k);

    // Direction reversal on left
    run_ticks(10);
    chk("rev_pwm_before", PWM_L_OUT, 1);
    DIR_L_IN = 1'b0;
    cyc();
    chk("rev_busy", BUSY_OUT, 1);
    chk("rev_pwm_low", PWM_L_OUT, 0);
    DUTY_L_IN = 8'd20;
    to_boundary();
    chk("rev_duty_16", dut.u_chan_l.r_duty, 16);
    for (int k = 49; k <= 52; k++) period(20, 255, 20 - 4 * (k - 47), min_i(4 * k, 255), k);
    DUTY_L_IN = 8'd0;
    run_ticks(DEAD - 1);
    chk("dead_busy", BUSY_OUT, 1);
    chk("dead_dir_old", DIR_L_OUT, 1);
    run_ticks(1);
    chk("dead_dir_new", DIR_L_OUT, 0);
    chk("dead_done_busy", BUSY_OUT, 0);
    chk("dead_duty0", dut.u_chan_l.r_duty, 0);
    period(0, 255, 0, 212, 53);

    // Duty 0 never high
    measure_period();
    chk("hi_l_0", hi_l, 0);
    chk("duty_r_p54", dut.u_chan_r.r_duty, 216);
    for (int k = 55; k <= 64; k++) period(0, 255, 0, min_i(4 * k, 255), k);

    // Duty 255 is 255 of 256 ticks
    measure_period();
    chk("meas_ticks_255", meas_ticks, 256);
    chk("hi_r_255", hi_r, 255);

    // Aborted reversal on right
    run_ticks(20);
    DIR_R_IN = 1'b0;
    cyc();
    chk("abort_busy", BUSY_OUT, 1);
    chk("abort_pwm_low", PWM_R_OUT, 0);
    run_ticks(3);
    DIR_R_IN = 1'b1;
    cyc();
    chk("abort_busy_clr", BUSY_OUT, 0);
    chk("abort_dir_r", DIR_R_OUT, 1);
    chk("abort_pwm_back", PWM_R_OUT, 1);
    chk("abort_duty_r", dut.u_chan_r.r_duty, 255);

    // Enable drop during dead time
    DIR_L_IN = 1'b1;
    cyc();
    chk("rev2_busy", BUSY_OUT, 1);
    to_boundary();
    run_ticks(5);
    chk("drop_busy_before", BUSY_OUT, 1);
    chk("drop_pwm_r_before", PWM_R_OUT, 1);
    ENABLE_IN = 1'b0;
    cyc();
    chk("drop_pwm_l", PWM_L_OUT, 0);
    chk("drop_pwm_r", PWM_R_OUT, 0);
    chk("drop_busy", BUSY_OUT, 0);
    chk("drop_dir_l_kept", DIR_L_OUT, 0);
    chk("drop_dir_r_kept", DIR_R_OUT, 1);
    chk("drop_duty_r", dut.u_chan_r.r_duty, 0);

    // Async reset while left PWM is high
    ENABLE_IN = 1'b1; DUTY_L_IN = 8'd100;
    cyc();
    chk("reen_dir_l", DIR_L_OUT, 1);
    to_boundary();
    chk("pre_rst_pwm_l", PWM_L_OUT, 1);
    RST = 1'b1;
    model_reset();
    #1;
    chk("arst_pwm_l", PWM_L_OUT, 0);
    chk("arst_pwm_r", PWM_R_OUT, 0);
    chk("arst_dir_l", DIR_L_OUT, 0);
    chk("arst_dir_r", DIR_R_OUT, 0);
    chk("arst_busy", BUSY_OUT, 0);
    cyc(); cyc();
    RST = 1'b0;
    cyc();
    chk("arst_cnt", dut.r_cnt, 0);
    chk("arst_duty_l", dut.u_chan_l.r_duty, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream consumer of the divided clock. Takes the divider's slow square wave as its PWM time base, not as a clock.
- Generates two independent PWM drive signals plus direction lines for the left and right motors of the line follower.
- Applies soft duty ramping and a brake/dead-time sequence on direction reversal, protecting the H-bridge.
- The whole block runs in the CLK_IN domain.

Parameters:
- PWM_BITS, 8, width of the period counter and of the duty inputs; PWM period = 2^PWM_BITS ticks.
- RAMP_STEP, 4, maximum duty change per channel per PWM period.
- DEAD_TICKS, 16, ticks with output held low between reaching zero duty and applying a new direction.

Ports:
- CLK_IN  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- TICK_IN  input  1  divided clock from the divider stage; each rising edge is one PWM tick.
- ENABLE_IN  input  1  motor enable; low forces both channels off.
- DUTY_L_IN  input  PWM_BITS  left target duty.
- DIR_L_IN  input  1  left requested direction (1 = forward).
- DUTY_R_IN  input  PWM_BITS  right target duty.
- DIR_R_IN  input  1  right requested direction.
- PWM_L_OUT  output  1  left PWM drive.
- DIR_L_OUT  output  1  left applied direction.
- PWM_R_OUT  output  1  right PWM drive.
- DIR_R_OUT  output  1  right applied direction.
- BUSY_OUT  output  1  high while either channel is in RAMP_DOWN or DEAD.

Behaviour:
- Reset (async, RST=1):
  - All outputs 0.
  - Period counter 0, both duty_cur 0, both FSMs IDLE, synchroniser flops 0.
- Tick generation:
  - TICK_IN passes through a 2-flop synchroniser, then a rising-edge detector.
  - tick is a one-CLK_IN-cycle pulse, 3 cycles after TICK_IN rises. A TICK_IN high level produces no further ticks.
- Period counter:
  - PWM_BITS wide; increments on tick, wraps 2^PWM_BITS-1 -> 0.
  - boundary = tick while counter == max.
- PWM output:
  - PWM_x_OUT is registered: PWM_x_OUT = (state==RUN) && (duty_cur_x > counter).
  - duty_cur 0 gives constant low; duty_cur 255 gives 255 high ticks out of 256. There is no 100% mode.
- Ramp, evaluated only at boundary, per channel:
  - Effective target = DUTY_x_IN, or 0 in RAMP_DOWN.
  - If duty_cur < target: duty_cur += min(RAMP_STEP, target - duty_cur).
  - If duty_cur > target: duty_cur -= min(RAMP_STEP, duty_cur - target).
  - No overflow or underflow; duty_cur never overshoots the target.
  - Duty inputs are sampled only at boundary; changes mid-period have no effect until the next boundary.
- Per-channel FSM:
  - IDLE:
    - PWM low, duty_cur held 0.
    - ENABLE_IN=1 -> RUN next cycle; DIR_x_OUT loads DIR_x_IN on that transition.
  - RUN:
    - Ramps toward DUTY_x_IN.
    - DIR_x_IN != DIR_x_OUT -> RAMP_DOWN.
  - RAMP_DOWN:
    - Ramps toward 0. The PWM output is gated by state==RUN, so it is already low here.
    - At the boundary where duty_cur reaches 0 -> DEAD; dead counter cleared.
    - If DIR_x_IN returns to equal DIR_x_OUT before that boundary -> back to RUN, continuing from the current duty_cur.
  - DEAD:
    - PWM low; counts ticks.
    - After DEAD_TICKS ticks -> RUN, DIR_x_OUT loads the current DIR_x_IN, duty_cur 0, ramp-up restarts.
  - From any state, ENABLE_IN=0 -> IDLE next cycle: PWM low immediately, duty_cur 0. DIR_x_OUT keeps its value.
- Channels are fully independent except for the shared counter and tick.
- BUSY_OUT = OR over channels of (state is RAMP_DOWN or DEAD), registered.
- Simultaneous events:
  - ENABLE_IN=0 has priority over all FSM transitions.
  - A direction change arriving on the boundary cycle takes effect in the FSM that cycle. The ramp update on that boundary still uses the pre-transition target.

Test Plan:
- Reset mid-run: RST pulsed while PWM_L_OUT=1 -> all outputs 0 in the same cycle (async); counter 0 after release.
- Ramp up: ENABLE=1, DUTY_L=100, DIR_L=1 -> duty_cur 4, 8, …, 100 over 25 periods, then PWM_L_OUT high exactly 100 of 256 ticks per period. DUTY_L=102 from duty_cur 100 -> 102 at the next boundary, no overshoot.
- Tick integrity: TICK_IN held high 50 CLK_IN cycles -> counter advances exactly 1. A rising edge -> counter change visible 3 cycles later.
- Direction reversal: running at duty 20, DIR_L 1 -> 0 -> BUSY_OUT=1, PWM_L_OUT low from that point; 5 boundaries to reach 0, then 16 ticks DEAD; DIR_L_OUT becomes 0, BUSY_OUT=0, ramp restarts from 0.
- Aborted reversal: DIR_R toggles 1 -> 0 -> 1 within one period -> returns to RUN from RAMP_DOWN, DIR_R_OUT stays 1, no DEAD phase.
- Enable drop and extremes: ENABLE_IN=0 during DEAD -> IDLE next cycle, both PWMs 0. DUTY=0 gives a never-high output; DUTY=255 gives 255/256 high.
